skill_scheduler: RTL and testbench
==================================

Name: skill_scheduler

Overview:
- Arbitrates the three player skill requests (J/K/L one-pulses) for the brick-breaker stage.
- Owns the shared skill-point budget and sequences each skill through its active window and cooldown.
- Sits between the keyboard one-pulse stage and ball_control/board logic; it replaces the ad-hoc skill_point/skill_remain bookkeeping.
- Its skill_active bits drive ball/board behaviour; points_led drives led[15:13].

Parameters:
- DUR_CYC, 120, active window length in clk_22 cycles (about 5 s); legal range 1..255.
- COOL_CYC, 48, cooldown length after the active window; legal range 0..255.
- MAX_POINT, 3, saturation value of the point budget; legal range 1..7.
- INIT_POINT, 3, point budget after reset; must be ≤ MAX_POINT.
- RECHARGE_HITS, 8, brick_hit pulses per point regained; legal range 1..255.

Ports:
- clk_22 input 1: game tick.
- rst input 1: reset.
- en input 1: high while the game state is STAGE1.
- skill_req input 3: one-cycle request pulses; bit0=J, bit1=K, bit2=L.
- brick_hit input 1: one-cycle pulse per brick destroyed.
- skill_grant output 3: one-hot, one-cycle pulse when a skill starts.
- skill_active output 3: high for the whole active window of each skill.
- skill_cool output 3: high during the cooldown of each skill.
- skill_point output 3: current budget, 0..MAX_POINT.
- points_led output 3: thermometer MSB-first (0→000, 1→100, 2→110, ≥3→111).

Interface: reset rst, asynchronous, active-high; clock clk_22. All outputs are registered.

Behaviour:
- Reset values:
  - skill_grant, skill_active and skill_cool are 0.
  - skill_point is INIT_POINT; points_led matches it.
  - Hit counter is 0; all skill FSMs are IDLE.
  - With SKILL_REQ_QUEUE_EN, the pending register is 0.
- Per-skill FSM:
  - States IDLE, ACTIVE, COOL, each with an 8-bit down-counter.
  - IDLE→ACTIVE on grant; the counter loads DUR_CYC−1.
  - ACTIVE decrements to 0. At 0 it moves to COOL (counter loads COOL_CYC−1), or straight to IDLE if COOL_CYC=0.
  - COOL decrements to 0, then moves to IDLE.
- Eligibility: skill i is eligible when en=1, its FSM is IDLE, and skill_point>0.
- Arbitration:
  - At most one grant per cycle.
  - Fixed priority bit0 > bit1 > bit2 among requested, eligible skills.
  - Losing requests are dropped unless the queue feature is enabled.
- Grant latency:
  - A request sampled at edge k gives skill_grant[i]=1 and skill_active[i]=1 after edge k.
  - skill_point decrements at the same edge.
  - skill_active[i] stays high for exactly DUR_CYC cycles.
  - skill_cool[i] then stays high for exactly COOL_CYC cycles.
- Recharge:
  - Each brick_hit increments the hit counter.
  - On reaching RECHARGE_HITS, the counter wraps to 0 and skill_point increments, saturating at MAX_POINT.
  - At saturation, hits are still counted and wrapped, but no point is added.
  - brick_hit is counted regardless of en.
- Simultaneous grant and recharge in the same cycle: net point change is 0.
- Grant at skill_point=1 together with recharge: the grant is allowed and the point stays at 1.
- skill_point=0: no grants; requests are dropped.
- en falling:
  - All FSMs go to IDLE and all counters clear on the next edge.
  - skill_active and skill_cool drop.
  - skill_point and the hit counter are held.
- rst mid-window: immediate asynchronous return to the reset values.

Optional Feature:
- Macro: SKILL_REQ_QUEUE_EN.
- With the macro:
  - A 3-bit pending register latches requests that lose arbitration, or that arrive while their FSM is ACTIVE/COOL or skill_point=0.
  - Pending bits join arbitration each cycle, ORed with new requests.
  - A bit clears on grant or when en=0.
  - Duplicate requests for the same skill collapse to one.
- Without the macro: non-granted requests are discarded and there is no pending state.

Decomposition:
- Shared package (skill_pkg):
  - Skill index constants SKILL_J=0, SKILL_K=1, SKILL_L=2.
  - FSM state encoding: IDLE=2'd0, ACTIVE=2'd1, COOL=2'd2.
  - Parameter defaults.
- Natural sub-module: skill_timer, one per skill (instantiated 3×).
  - Holds the per-skill FSM and down-counter.
  - Inputs: start, clear.
  - Outputs: active, cool, idle.
- The top level holds the arbiter, the point budget, the hit counter and the optional pending register.

Test Plan:
- Reset, en=1, skill_req=3'b001 for one cycle → skill_grant=001 for 1 cycle; skill_active[0] high for 120 cycles, then skill_cool[0] for 48 cycles; skill_point 3→2; points_led=110.
- skill_req=3'b111 in one cycle with points=3 → only skill_grant=001; skill_point=2; bits 1 and 2 stay IDLE (macro off). With SKILL_REQ_QUEUE_EN: K is granted next cycle, then L; skill_point ends at 0.
- Points=0, skill_req=3'b010 → no grant. Then 8 brick_hit pulses → skill_point=1, points_led=100. Then skill_req=3'b010 → grant=010.
- Points=1 with brick_hit (completing 8 hits) and skill_req=001 in the same cycle → grant=001, skill_point stays 1.
- Skill J active at cycle 50, en deasserted → next edge skill_active=000, skill_cool=000, points unchanged. en reasserted with req 001 → immediate grant.
- Points=3 (MAX) plus 16 brick_hit pulses → skill_point stays 3. Assert rst mid-ACTIVE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/skill_pkg.sv
// Shared constants, FSM encoding and helpers for the skill scheduler slice.
package skill_pkg;

    localparam int unsigned NUM_SKILL = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned PT_W      = 3;

    localparam int unsigned SKILL_J = 0;
    localparam int unsigned SKILL_K = 1;
    localparam int unsigned SKILL_L = 2;

    localparam int unsigned DUR_CYC_DEF       = 120;
    localparam int unsigned COOL_CYC_DEF      = 48;
    localparam int unsigned MAX_POINT_DEF     = 3;
    localparam int unsigned INIT_POINT_DEF    = 3;
    localparam int unsigned RECHARGE_HITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COOL   = 2'd2
    } skill_state_e;

    // Thermometer display of the budget, MSB first, saturating at three lamps.
    function automatic logic [2:0] point_to_led(input logic [PT_W-1:0] pt);
        logic [2:0] led;
        case (pt)
            3'd0:    led = 3'b000;
            3'd1:    led = 3'b100;
            3'd2:    led = 3'b110;
            default: led = 3'b111;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/skill_timer.sv
// Per-skill IDLE -> ACTIVE -> COOL sequencer with an 8-bit down-counter.
module skill_timer
    import skill_pkg::*;
#(
    parameter int unsigned DUR_CYC  = DUR_CYC_DEF,
    parameter int unsigned COOL_CYC = COOL_CYC_DEF
) (
    input  logic clk_22,
    input  logic rst,
    input  logic start_i,
    input  logic clear_i,
    output logic active_o,
    output logic cool_o,
    output logic idle_o
);

    localparam logic [CNT_W-1:0] DUR_LOAD  = CNT_W'(DUR_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = (COOL_CYC == 0) ? '0 : CNT_W'(COOL_CYC - 1);

    skill_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_o <= 1'b0;
            cool_o   <= 1'b0;
            idle_o   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_o <= (state_d == ACTIVE);
            cool_o   <= (state_d == COOL);
            idle_o   <= (state_d == IDLE);
        end
    end

    // Clear wins over everything so a stage exit always lands in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = ACTIVE;
                        cnt_d   = DUR_LOAD;
                    end
                end
                ACTIVE: begin
                    if (cnt_q == '0) begin
                        if (COOL_CYC == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = COOL;
                            cnt_d   = COOL_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                COOL: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/skill_scheduler.sv
// Skill arbiter, shared point budget and brick-hit recharge for the stage.
// Define SKILL_REQ_QUEUE_EN to hold non-granted requests until they can be served.
module skill_scheduler
    import skill_pkg::*;
#(
    parameter int unsigned DUR_CYC       = DUR_CYC_DEF,
    parameter int unsigned COOL_CYC      = COOL_CYC_DEF,
    parameter int unsigned MAX_POINT     = MAX_POINT_DEF,
    parameter int unsigned INIT_POINT    = INIT_POINT_DEF,
    parameter int unsigned RECHARGE_HITS = RECHARGE_HITS_DEF
) (
    input  logic                 clk_22,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_SKILL-1:0] skill_req,
    input  logic                 brick_hit,
    output logic [NUM_SKILL-1:0] skill_grant,
    output logic [NUM_SKILL-1:0] skill_active,
    output logic [NUM_SKILL-1:0] skill_cool,
    output logic [PT_W-1:0]      skill_point,
    output logic [2:0]           points_led
);

    localparam logic [PT_W-1:0]  MAX_PT   = PT_W'(MAX_POINT);
    localparam logic [PT_W-1:0]  INIT_PT  = PT_W'(INIT_POINT);
    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(RECHARGE_HITS - 1);

    logic [NUM_SKILL-1:0] idle_w;
    logic [NUM_SKILL-1:0] req_c, elig_c, cand_c, grant_d;
    logic [CNT_W-1:0]     hit_q, hit_d;
    logic [PT_W-1:0]      point_d;
    logic                 recharge_c;

`ifdef SKILL_REQ_QUEUE_EN
    logic [NUM_SKILL-1:0] pend_q, pend_d;

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign req_c = skill_req | pend_q;
    // Anything requested but not served this cycle stays pending while in stage.
    always_comb begin
        pend_d = '0;
        if (en) pend_d = req_c & ~grant_d;
    end
`else
    assign req_c = skill_req;
`endif

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            skill_grant <= '0;
            skill_point <= INIT_PT;
            points_led  <= point_to_led(INIT_PT);
            hit_q       <= '0;
        end else begin
            skill_grant <= grant_d;
            skill_point <= point_d;
            points_led  <= point_to_led(point_d);
            hit_q       <= hit_d;
        end
    end

    // Fixed priority J > K > L among requested, eligible skills.
    always_comb begin
        elig_c  = (en && (skill_point != '0)) ? idle_w : '0;
        cand_c  = req_c & elig_c;
        grant_d = '0;
        if (cand_c[SKILL_J])      grant_d[SKILL_J] = 1'b1;
        else if (cand_c[SKILL_K]) grant_d[SKILL_K] = 1'b1;
        else if (cand_c[SKILL_L]) grant_d[SKILL_L] = 1'b1;
    end

    // A grant and a recharge in the same cycle cancel, even at saturation.
    always_comb begin
        hit_d      = hit_q;
        recharge_c = 1'b0;
        if (brick_hit) begin
            if (hit_q == HIT_LAST) begin
                hit_d      = '0;
                recharge_c = 1'b1;
            end else begin
                hit_d = hit_q + CNT_W'(1);
            end
        end
        point_d = skill_point;
        if ((|grant_d) && recharge_c) begin
            point_d = skill_point;
        end else if (|grant_d) begin
            point_d = skill_point - PT_W'(1);
        end else if (recharge_c && (skill_point < MAX_PT)) begin
            point_d = skill_point + PT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_SKILL; i++) begin : g_timer
        skill_timer #(
            .DUR_CYC  (DUR_CYC),
            .COOL_CYC (COOL_CYC)
        ) u_timer (
            .clk_22   (clk_22),
            .rst      (rst),
            .start_i  (grant_d[i]),
            .clear_i  (~en),
            .active_o (skill_active[i]),
            .cool_o   (skill_cool[i]),
            .idle_o   (idle_w[i])
        );
    end

endmodule

// File: tb/tb_skill_scheduler.sv
// Directed bench for skill_scheduler with a grant scoreboard and a negedge monitor.
module tb_skill_scheduler;

    localparam int DUR  = 120;
    localparam int COOL = 48;

    typedef struct packed {
        logic [2:0] grant;
        logic [2:0] point;
        logic [2:0] led;
    } exp_t;

    logic       clk_22 = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] skill_req;
    logic       brick_hit;
    logic [2:0] skill_grant, skill_active, skill_cool, skill_point, points_led;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    skill_scheduler dut (
        .clk_22       (clk_22),
        .rst          (rst),
        .en           (en),
        .skill_req    (skill_req),
        .brick_hit    (brick_hit),
        .skill_grant  (skill_grant),
        .skill_active (skill_active),
        .skill_cool   (skill_cool),
        .skill_point  (skill_point),
        .points_led   (points_led)
    );

    always #5 clk_22 = ~clk_22;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Every grant pulse must match the next expected record.
    always @(negedge clk_22) begin
        if (!rst && skill_grant != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", int'(skill_grant), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_grant", int'(skill_grant), int'(e.grant));
                chk("sb_point", int'(skill_point), int'(e.point));
                chk("sb_led", int'(points_led), int'(e.led));
                chk("sb_active", int'(skill_active & e.grant), int'(e.grant));
            end
        end
    end

    task automatic cyc();
        @(posedge clk_22);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        skill_req = r;
        cyc();
        skill_req = 3'b000;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            brick_hit = 1'b1;
            cyc();
        end
        brick_hit = 1'b0;
    endtask

    task automatic en_pulse_low();
        en = 1'b0;
        cyc();
        en = 1'b1;
    endtask

    task automatic push(input logic [2:0] g, input logic [2:0] p, input logic [2:0] l);
        exp_t e;
        e.grant = g;
        e.point = p;
        e.led   = l;
        exp_q.push_back(e);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; skill_req = 3'b000; brick_hit = 1'b0;
        #22;
        chk("rst_point", int'(skill_point), 3);
        chk("rst_led", int'(points_led), 3'b111);
        chk("rst_grant", int'(skill_grant), 0);
        chk("rst_active", int'(skill_active), 0);
        chk("rst_cool", int'(skill_cool), 0);
        cyc();
        rst = 1'b0;
        en  = 1'b1;
        cyc();

        // Single J grant: window and cooldown lengths.
        push(3'b001, 3'd2, 3'b110);
        pulse_req(3'b001);
        chk("j_active_start", int'(skill_active), 3'b001);
        n = 0;
        while (skill_active[0] && n < 300) begin cyc(); n++; end
        chk("j_active_len", n, DUR);
        chk("j_cool_start", int'(skill_cool), 3'b001);
        n = 0;
        while (skill_cool[0] && n < 300) begin cyc(); n++; end
        chk("j_cool_len", n, COOL);
        chk("j_idle_active", int'(skill_active), 0);
        chk("j_idle_cool", int'(skill_cool), 0);

        hits(8);
        chk("recharge_to_3", int'(skill_point), 3);
        chk("recharge_led", int'(points_led), 3'b111);

        // All three requested together.
        push(3'b001, 3'd2, 3'b110);
`ifdef SKILL_REQ_QUEUE_EN
        push(3'b010, 3'd1, 3'b100);
        push(3'b100, 3'd0, 3'b000);
`endif
        pulse_req(3'b111);
        chk("multi_first_grant", int'(skill_grant), 3'b001);
        cyc();
        cyc();
`ifdef SKILL_REQ_QUEUE_EN
        chk("multi_queued_active", int'(skill_active), 3'b111);
        chk("multi_queued_point", int'(skill_point), 0);
`else
        chk("multi_only_j", int'(skill_active), 3'b001);
        chk("multi_point", int'(skill_point), 2);
`endif
        en = 1'b0;
        cyc();
        chk("en_low_active", int'(skill_active), 0);
        chk("en_low_cool", int'(skill_cool), 0);
`ifdef SKILL_REQ_QUEUE_EN
        chk("en_low_point", int'(skill_point), 0);
        en = 1'b1;
`else
        chk("en_low_point", int'(skill_point), 2);
        en = 1'b1;
        push(3'b010, 3'd1, 3'b100);
        pulse_req(3'b010);
        push(3'b100, 3'd0, 3'b000);
        pulse_req(3'b100);
`endif

        // Empty budget: request refused, then earned back.
        en_pulse_low();
        pulse_req(3'b010);
        chk("zero_no_grant", int'(skill_grant), 0);
        chk("zero_no_active", int'(skill_active), 0);
        chk("zero_point", int'(skill_point), 0);
        en_pulse_low();
        cyc();
        hits(8);
        chk("zero_recharge_point", int'(skill_point), 1);
        chk("zero_recharge_led", int'(points_led), 3'b100);
        push(3'b010, 3'd0, 3'b000);
        pulse_req(3'b010);
        chk("zero_then_k", int'(skill_active), 3'b010);

        // Grant at one point coinciding with the eighth hit.
        en_pulse_low();
        hits(8);
        hits(7);
        chk("pre_coinc_point", int'(skill_point), 1);
        push(3'b001, 3'd1, 3'b100);
        brick_hit = 1'b1;
        skill_req = 3'b001;
        cyc();
        brick_hit = 1'b0;
        skill_req = 3'b000;
        chk("coinc_point", int'(skill_point), 1);
        chk("coinc_active", int'(skill_active), 3'b001);

        // Stage exit mid-window, then immediate re-grant.
        for (int i = 0; i < 49; i++) cyc();
        chk("mid_window_active", int'(skill_active), 3'b001);
        en = 1'b0;
        cyc();
        chk("exit_active", int'(skill_active), 0);
        chk("exit_cool", int'(skill_cool), 0);
        chk("exit_point", int'(skill_point), 1);
        en = 1'b1;
        push(3'b001, 3'd0, 3'b000);
        pulse_req(3'b001);
        chk("reenter_active", int'(skill_active), 3'b001);

        // Saturation: surplus hits still wrap the counter.
        en_pulse_low();
        hits(24);
        chk("sat_reach_3", int'(skill_point), 3);
        hits(16);
        chk("sat_hold_3", int'(skill_point), 3);
        push(3'b001, 3'd2, 3'b110);
        pulse_req(3'b001);
        hits(8);
        chk("sat_wrap_regain", int'(skill_point), 3);
        chk("sat_j_active", int'(skill_active), 3'b001);

        // Asynchronous reset in the middle of the window.
        @(posedge clk_22);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_active", int'(skill_active), 0);
        chk("async_rst_cool", int'(skill_cool), 0);
        chk("async_rst_grant", int'(skill_grant), 0);
        chk("async_rst_point", int'(skill_point), 3);
        chk("async_rst_led", int'(points_led), 3'b111);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
